// File: rtl/vec_tx_pkg.sv
// rtl/vec_tx_pkg.sv - shared constants, word/index types and read-side states for vec_tx_16_12
package vec_tx_pkg;

    localparam int VEC_T  = 12;
    localparam int VEC_N  = 16;
    localparam int VEC_AW = $clog2(VEC_N);

    typedef logic signed [VEC_T-1:0] word_t;
    typedef logic [VEC_AW-1:0]       idx_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_SEND = 1'b1
    } rd_state_t;

endpackage

// File: rtl/vec_tx_bank.sv
// rtl/vec_tx_bank.sv - one ping-pong bank: word storage, full flag, write port, combinational read port
module vec_tx_bank
    import vec_tx_pkg::*;
#(
    parameter int T = VEC_T,
    parameter int N = VEC_N
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [$clog2(N)-1:0]   wr_addr,
    input  logic signed [T-1:0]    wr_data,
    input  logic                   set_full,
    input  logic                   clr_full,
    input  logic [$clog2(N)-1:0]   rd_addr,
    output logic signed [T-1:0]    rd_data,
    output logic                   full
);

    logic signed [T-1:0] mem [N];

    // Storage is deliberately not reset; only the write is blocked during reset.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 1'b0;
        end else if (set_full) begin
            full <= 1'b1;
        end else if (clr_full) begin
            full <= 1'b0;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/vec_tx_16_12.sv
// rtl/vec_tx_16_12.sv - ping-pong vector buffer streaming N words per frame; optional VEC_TX_FRAME_CNT_EN adds frames_sent
module vec_tx_16_12
    import vec_tx_pkg::*;
#(
    parameter int T = VEC_T,
    parameter int N = VEC_N
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic signed [T-1:0]    wr_data,
    input  logic [$clog2(N)-1:0]   wr_addr,
    input  logic                   wr_en,
    input  logic                   commit,
    output logic                   wr_ready,
    output logic signed [T-1:0]    x_data,
    output logic                   x_valid,
    input  logic                   x_ready
`ifdef VEC_TX_FRAME_CNT_EN
    ,
    output logic [31:0]            frames_sent
`endif
);

    localparam int AW = $clog2(N);

    logic                wb;
    logic                rb;
    logic                rb_nx;
    logic [AW-1:0]       idx;
    logic [1:0]          full;
    logic [1:0]          full_nx;
    logic signed [T-1:0] rd_word [2];
    rd_state_t           state;
    rd_state_t           state_nx;

    logic do_write;
    logic do_commit;
    logic accept;
    logic last;

    assign wr_ready  = ~full[wb];
    assign do_write  = wr_en & wr_ready;
    assign do_commit = commit & wr_ready;
    assign accept    = x_valid & x_ready;
    assign last      = accept && (idx == AW'(N - 1));

    for (genvar i = 0; i < 2; i++) begin : g_bank
        vec_tx_bank #(
            .T (T),
            .N (N)
        ) u_bank (
            .clk      (clk),
            .reset    (reset),
            .wr_en    (do_write && (wb == 1'(i))),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .set_full (do_commit && (wb == 1'(i))),
            .clr_full (last && (rb == 1'(i))),
            .rd_addr  (idx),
            .rd_data  (rd_word[i]),
            .full     (full[i])
        );
    end

    // The read side sends whenever the bank it will point at is full next cycle,
    // which gives both the one-cycle commit latency and back-to-back frames.
    always_comb begin
        full_nx = full;
        if (last) begin
            full_nx[rb] = 1'b0;
        end
        if (do_commit) begin
            full_nx[wb] = 1'b1;
        end
        rb_nx    = last ? ~rb : rb;
        state_nx = full_nx[rb_nx] ? RD_SEND : RD_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RD_IDLE;
            wb    <= 1'b0;
            rb    <= 1'b0;
            idx   <= '0;
        end else begin
            state <= state_nx;
            rb    <= rb_nx;
            if (do_commit) begin
                wb <= ~wb;
            end
            if (last) begin
                idx <= '0;
            end else if (accept) begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign x_valid = (state == RD_SEND);
    assign x_data  = x_valid ? rd_word[rb] : '0;

`ifdef VEC_TX_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            frames_sent <= '0;
        end else if (last) begin
            frames_sent <= frames_sent + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vec_tx_16_12.sv
// tb/tb_vec_tx_16_12.sv - randomized self-checking bench for vec_tx_16_12 against a frame-queue model
module tb_vec_tx_16_12;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic        commit;
    logic        x_ready;
    logic        wr_ready;
    logic        x_valid;
    logic [3:0]  wr_addr;
    logic [11:0] wr_data;
    logic [11:0] x_data;
`ifdef VEC_TX_FRAME_CNT_EN
    logic [31:0] frames_sent;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Model: bank contents, write-bank pointer, and the queue of words still owed downstream.
    logic [11:0] mem_m [2][N];
    int          wb_m;
    logic [11:0] wq [$];
    int          frames_m;
    logic        prev_hold;
    logic [11:0] prev_data;

    always #5 clk = ~clk;

    vec_tx_16_12 dut (
        .clk      (clk),
        .reset    (reset),
        .wr_data  (wr_data),
        .wr_addr  (wr_addr),
        .wr_en    (wr_en),
        .commit   (commit),
        .wr_ready (wr_ready),
        .x_data   (x_data),
        .x_valid  (x_valid),
        .x_ready  (x_ready)
`ifdef VEC_TX_FRAME_CNT_EN
        ,
        .frames_sent (frames_sent)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        logic        exp_valid;
        logic [11:0] exp_data;
        logic        rdy;
        @(negedge clk);
        exp_valid = (wq.size() > 0);
        exp_data  = exp_valid ? wq[0] : 12'h000;
        rdy       = ((wq.size() + N - 1) / N) < 2;
        check("wr_ready", 32'(wr_ready), 32'(rdy));
        check("x_valid", 32'(x_valid), 32'(exp_valid));
        check("x_data", 32'(x_data), 32'(exp_data));
        if (prev_hold) check("hold", 32'(x_data), 32'(prev_data));
`ifdef VEC_TX_FRAME_CNT_EN
        check("frames_sent", frames_sent, 32'(frames_m));
`endif
        prev_hold = exp_valid && !x_ready && !reset;
        prev_data = x_data;
        if (reset) begin
            wq.delete();
            wb_m     = 0;
            frames_m = 0;
        end else begin
            if (exp_valid && x_ready) begin
                void'(wq.pop_front());
                if (wq.size() % N == 0) frames_m++;
            end
            if (wr_en && rdy) mem_m[wb_m][wr_addr] = wr_data;
            if (commit && rdy) begin
                for (int i = 0; i < N; i++) wq.push_back(mem_m[wb_m][i]);
                wb_m ^= 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic rst, input logic we, input logic [3:0] a,
                       input logic [11:0] d, input logic cm, input logic xr);
        reset   = rst;
        wr_en   = we;
        wr_addr = a;
        wr_data = d;
        commit  = cm;
        x_ready = xr;
        tick();
    endtask

    task automatic load_frame(input logic [11:0] base, input logic rnd, input logic xr);
        for (int i = 0; i < N; i++)
            cyc(1'b0, 1'b1, 4'(i), rnd ? 12'($urandom) : base + 12'(i), i == N - 1, xr);
    endtask

    initial begin
        int cnt;
        int start;
        int cycles;
        prev_hold = 1'b0;
        wq.delete();
        wb_m = 0;
        frames_m = 0;
        for (int b = 0; b < 2; b++) for (int i = 0; i < N; i++) mem_m[b][i] = 12'h000;
        reset = 1'b1; wr_en = 1'b0; commit = 1'b0; x_ready = 1'b0;
        wr_addr = '0; wr_data = '0;
        @(posedge clk);
        #1;
        cyc(1'b1, 1'b0, 4'd0, 12'd0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 4'd0, 12'd0, 1'b0, 1'b0);

        // Single frame 1..16, last word written together with commit
        load_frame(12'd1, 1'b0, 1'b1);
        repeat (20) cyc(1'b0, 1'b0, 4'd0, 12'd0, 1'b0, 1'b1);

        // Two frames queued, then streamed back to back
        load_frame(12'd1, 1'b0, 1'b0);
        load_frame(12'd101, 1'b0, 1'b0);
        cnt = 0;
        for (int k = 0; k < 32; k++) begin
            if (x_valid) cnt++;
            cyc(1'b0, 1'b0, 4'd0, 12'd0, 1'b0, 1'b1);
        end
        check("contiguous", 32'(cnt), 32'd32);
        repeat (4) cyc(1'b0, 1'b0, 4'd0, 12'd0, 1'b0, 1'b1);

        // Write and commit while both banks are full are dropped
        load_frame(12'd0, 1'b1, 1'b0);
        load_frame(12'd0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 4'd3, 12'h7FF, 1'b1, 1'b0);
        repeat (40) cyc(1'b0, 1'b0, 4'd0, 12'd0, 1'b0, 1'b1);

        // Reset after word 7 with the other bank committed
        load_frame(12'd0, 1'b1, 1'b0);
        load_frame(12'd0, 1'b1, 1'b0);
        repeat (8) cyc(1'b0, 1'b0, 4'd0, 12'd0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 4'd2, 12'd5, 1'b1, 1'b1);
        check("rst_x_valid", 32'(x_valid), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        repeat (20) cyc(1'b0, 1'b0, 4'd0, 12'd0, 1'b0, 1'b1);

        // Randomized traffic with 50% back-pressure
        start  = frames_m;
        cycles = 0;
        while ((frames_m - start) < 625 && cycles < 40000) begin
            cyc(1'b0, $urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), 12'($urandom),
                $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)));
            cycles++;
        end
        check("rand_frames", 32'((frames_m - start) >= 625), 32'd1);
        repeat (40) cyc(1'b0, 1'b0, 4'd0, 12'd0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vec_tx_16_12.md
VEC_TX_16_12 -- requirements
Module: vec_tx_16_12

Interface
REQ-001 Parameter T, default 12, signed data word width in bits.
REQ-002 Parameter N, default 16, words per vector (frame).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 wr_data  input  T  word to store in the current write bank.
REQ-006 wr_addr  input  $clog2(N)  word index within the write bank.
REQ-007 wr_en  input  1  write strobe; qualified by wr_ready.
REQ-008 commit  input  1  marks the write bank complete; qualified by wr_ready.
REQ-009 wr_ready  output  1  the write bank is empty and may be loaded.
REQ-010 x_data  output  T  streamed word, the input stream of conv_16_4_12_1.
REQ-011 x_valid  output  1  x_data holds a valid word.
REQ-012 x_ready  input  1  the downstream consumer accepts x_data this cycle.

Function
REQ-013 The block SHALL hold two N-word banks (ping-pong), each with a full flag, a write-bank pointer wb and a read-bank pointer rb.
REQ-014 wr_ready SHALL equal NOT full[wb].
REQ-015 When wr_en and wr_ready are both 1, mem[wb][wr_addr] SHALL take wr_data at the clock edge. When wr_en is 1 and wr_ready is 0, the write SHALL be ignored.
REQ-016 When commit and wr_ready are both 1, full[wb] SHALL set and wb SHALL toggle. A wr_en in the same cycle SHALL be stored into the committed bank before it is marked full.
REQ-017 A commit while wr_ready is 0 SHALL be ignored. Unwritten words of a committed bank SHALL be sent with their previous contents.
REQ-018 The read side SHALL have two states. IDLE: x_valid is 0 and rb's bank is not full. SEND: x_valid is 1 and words mem[rb][idx] are sent for idx = 0..N-1.
REQ-019 Transfer rule: a word is accepted when x_valid and x_ready are both 1 at a clock edge. idx SHALL advance only on an accepted word.
REQ-020 Once x_valid is asserted, it and x_data SHALL stay stable until the word is accepted, independent of x_ready.
REQ-021 Latency: the first word of a committed bank SHALL appear (x_valid=1) on the cycle after the commit edge, provided the read side is IDLE.
REQ-022 On acceptance of word N-1, full[rb] SHALL clear, rb SHALL toggle and idx SHALL return to 0.
REQ-023 If the other bank is full when word N-1 is accepted, x_valid SHALL remain 1 and word 0 of the next bank SHALL follow with no bubble. Otherwise the read side SHALL return to IDLE.
REQ-024 When the last word of a bank is accepted and a commit of the other bank occurs in the same cycle, both actions SHALL take effect. The bank freed this cycle SHALL show wr_ready=1 on the next cycle.
REQ-025 x_data SHALL be 0 whenever x_valid is 0.
REQ-026 Peak throughput SHALL be one word per cycle while x_ready is held at 1.

Reset
REQ-027 On reset=1 at a clock edge, the block SHALL set both full flags to 0, wb=0, rb=0, idx=0, x_valid=0, x_data=0; wr_ready SHALL read 1 on the following cycle.
REQ-028 Bank memory contents SHALL NOT be reset.
REQ-029 Reset mid-frame SHALL discard both the partial frame and any committed-but-unsent frame.
REQ-030 Reset SHALL take priority over wr_en, commit and x_ready in the same cycle.

Configuration
REQ-031 Macro VEC_TX_FRAME_CNT_EN, when defined, SHALL add the output port frames_sent (32 bits). The counter resets to 0, increments on each accepted word N-1 and wraps at 2^32.
REQ-032 Without VEC_TX_FRAME_CNT_EN, frames_sent SHALL NOT exist and all other behaviour SHALL be identical.

Structure
REQ-033 Package vec_tx_pkg SHALL hold the constants VEC_T=12, VEC_N=16, VEC_AW=$clog2(VEC_N), the typedef word_t (signed [VEC_T-1:0]) and the typedef idx_t.
REQ-034 Sub-module vec_tx_bank SHALL implement one bank: storage, full flag, write port and combinational read port. vec_tx_16_12 SHALL instantiate it twice.

Verification
REQ-035 Scenario: reset, write words 0..15 = 1..16, commit, x_ready held at 1 -> x_valid rises on the cycle after commit; x_data = 1..16 on 16 consecutive cycles; then x_valid=0.
REQ-036 Scenario: commit bank 0 (values 1..16), then commit bank 1 (values 101..116) while bank 0 is sending -> 32 contiguous words with no bubble; wr_ready=0 until word 15 of bank 0 is accepted.
REQ-037 Scenario: x_ready randomized at 50%, 625 frames, values checked against a model -> every word is delivered in order; x_data never changes while x_valid=1 and x_ready=0.
REQ-038 Scenario: both banks full, then wr_en with wr_addr=3 and wr_data=12'h7FF plus commit -> both ignored; the next frames carry the original data.
REQ-039 Scenario: reset asserted after word 7 is accepted, with the second bank committed -> on the next cycle x_valid=0 and wr_ready=1; no word of either frame is sent after reset.
REQ-040 Scenario (VEC_TX_FRAME_CNT_EN defined): 3 frames sent -> frames_sent = 3; after reset frames_sent = 0.
